// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings and the NOP instruction word.
package hazard_ctrl_pkg;

  // Hazard controller states; encoding 3 is never entered deliberately and falls back to RUN
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  // ADDI x0, x0, 0 -- the word a squashed pipeline register is loaded with
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags when the ID instruction reads a register that an EX load is still producing.
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = 5
) (
  input  logic [REG_NUM_BITWIDTH-1:0] i_id_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] i_id_rs2,
  input  logic                        i_id_uses_rs1,
  input  logic                        i_id_uses_rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] i_ex_rd,
  input  logic                        i_ex_mem_read,
  output logic                        o_load_use
);

  logic w_load_pending;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // A load into x0 never produces a value anyone waits for, so it is excluded up front
  always_comb begin
    w_load_pending = i_ex_mem_read && (i_ex_rd != '0);
    w_rs1_hit      = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    w_rs2_hit      = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    o_load_use     = w_load_pending && (w_rs1_hit || w_rs2_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory wait, redirect flush and load-use stall, plus a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int CNT_BITWIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
  input  logic                        id_uses_rs1,
  input  logic                        id_uses_rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
  input  logic                        ex_mem_read,
  input  logic                        ex_branch_taken,
  input  logic                        mem_busy,
  input  logic                        clr_stats,
  output logic                        pc_hold,
  output logic                        hz_write,
  output logic                        if_id_flush,
  output logic                        id_ex_bubble,
  output logic                        ex_mem_hold,
  output logic [CNT_BITWIDTH-1:0]     stall_count,
  output logic [1:0]                  state_o
);

  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = {CNT_BITWIDTH{1'b1}};

  state_t                  r_state;
  logic [CNT_BITWIDTH-1:0] r_stall_count;

  state_t w_next_state;
  logic   w_load_use;
  logic   w_in_flush;
  logic   w_pc_hold;
  logic   w_hz_write;
  logic   w_if_id_flush;
  logic   w_id_ex_bubble;
  logic   w_ex_mem_hold;

  hazard_detect #(
    .REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)
  ) u_detect (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

  // Only FLUSH carries obligations into the next cycle; MEM_WAIT and the unused code behave like RUN
  always_comb begin
    case (r_state)
      ST_FLUSH: w_in_flush = 1'b1;
      default:  w_in_flush = 1'b0;
    endcase
  end

  // Control outputs and next state from the current state and inputs, highest priority first
  always_comb begin
    w_pc_hold      = 1'b0;
    w_hz_write     = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_ex_mem_hold  = 1'b0;
    w_next_state   = ST_RUN;
    if (rst) begin
      w_next_state = ST_RUN;
    end else if (mem_busy) begin
      w_pc_hold     = 1'b1;
      w_hz_write    = 1'b1;
      w_ex_mem_hold = 1'b1;
      w_next_state  = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_next_state   = ST_FLUSH;
    end else if (w_in_flush) begin
      // The instruction in ID is the wrong-path fetch, so squashing it beats any load-use stall on it
      w_if_id_flush = 1'b1;
      w_next_state  = ST_RUN;
    end else if (w_load_use) begin
      w_pc_hold      = 1'b1;
      w_hz_write     = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_next_state   = ST_RUN;
    end
  end

  // FSM state and saturating stall counter; clearing the statistics wins over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (clr_stats) begin
        r_stall_count <= '0;
      end else if (w_pc_hold && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
    end
  end

  assign pc_hold      = w_pc_hold;
  assign hz_write     = w_hz_write;
  assign if_id_flush  = w_if_id_flush;
  assign id_ex_bubble = w_id_ex_bubble;
  assign ex_mem_hold  = w_ex_mem_hold;
  assign stall_count  = r_stall_count;
  assign state_o      = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a rule-level model of the controller.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        clr_stats;
  logic        pc_hold;
  logic        hz_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_hold;
  logic [15:0] stall_count;
  logic [1:0]  state_o;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model memory: what happened last cycle, and the stall count it implies
  bit busyLast     = 0;
  bit redirectLast = 0;
  int mCount       = 0;
  bit pBusy        = 0;
  bit pRedirect    = 0;
  int pCount       = 0;

  hazard_ctrl #(
    .REG_NUM_BITWIDTH(5),
    .CNT_BITWIDTH(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .clr_stats       (clr_stats),
    .pc_hold         (pc_hold),
    .hz_write        (hz_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .stall_count     (stall_count),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic busy, input logic br, input logic mr,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic clr);
    @(posedge clk);
    #1;
    rst             = rstV;
    mem_busy        = busy;
    ex_branch_taken = br;
    ex_mem_read     = mr;
    ex_rd           = rd;
    id_rs1          = rs1;
    id_uses_rs1     = u1;
    id_rs2          = rs2;
    id_uses_rs2     = u2;
    clr_stats       = clr;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
  endtask

  // Model reset tracks the asynchronous reset; otherwise commit what last negedge predicted
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busyLast     = 0;
      redirectLast = 0;
      mCount       = 0;
    end else begin
      busyLast     = pBusy;
      redirectLast = pRedirect;
      mCount       = pCount;
    end
  end

  // Compare process: mid-cycle, derive required outputs from the rules and check every output
  always @(negedge clk) begin
    bit lu;
    bit eHold, eHz, eFlush, eBub, eExm;
    int eState;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    eHold = 0; eHz = 0; eFlush = 0; eBub = 0; eExm = 0;
    if (rst) begin
      eState = 0;
    end else begin
      eState = busyLast ? 1 : (redirectLast ? 2 : 0);
      if (mem_busy) begin
        eHold = 1; eHz = 1; eExm = 1;
      end else if (ex_branch_taken) begin
        eFlush = 1; eBub = 1;
      end else if (redirectLast) begin
        eFlush = 1;
      end else if (lu) begin
        eHold = 1; eHz = 1; eBub = 1;
      end
    end
    checkOutput("pc_hold", {31'd0, pc_hold}, {31'd0, eHold});
    checkOutput("hz_write", {31'd0, hz_write}, {31'd0, eHz});
    checkOutput("if_id_flush", {31'd0, if_id_flush}, {31'd0, eFlush});
    checkOutput("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, eBub});
    checkOutput("ex_mem_hold", {31'd0, ex_mem_hold}, {31'd0, eExm});
    checkOutput("state_o", {30'd0, state_o}, eState);
    checkOutput("stall_count", {16'd0, stall_count}, rst ? 0 : mCount);
    if (rst) begin
      pBusy = 0; pRedirect = 0; pCount = 0;
    end else begin
      pBusy     = mem_busy;
      pRedirect = ex_branch_taken && !mem_busy;
      if (clr_stats)  pCount = 0;
      else if (eHold) pCount = (mCount >= 65535) ? 65535 : mCount + 1;
      else            pCount = mCount;
    end
  end

  initial begin
    rst = 1; mem_busy = 0; ex_branch_taken = 0; ex_mem_read = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; clr_stats = 0;

    // Reset state
    #12;
    checkOutput("reset pc_hold", {31'd0, pc_hold}, 0);
    checkOutput("reset state", {30'd0, state_o}, 0);
    checkOutput("reset count", {16'd0, stall_count}, 0);
    idleCycle();

    // Load-use on rs1: one stall cycle, counted once
    applyStimulus(0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    #2;
    checkOutput("lu pc_hold", {31'd0, pc_hold}, 1);
    checkOutput("lu hz_write", {31'd0, hz_write}, 1);
    checkOutput("lu bubble", {31'd0, id_ex_bubble}, 1);
    idleCycle();
    #2;
    checkOutput("lu count", {16'd0, stall_count}, 1);

    // Load into x0, and an rs2 match that is not read: no stall
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0);
    #2;
    checkOutput("x0 no stall", {31'd0, pc_hold}, 0);
    applyStimulus(0, 0, 0, 1, 5'd7, 5'd1, 1, 5'd7, 0, 0);
    #2;
    checkOutput("rs2 unused no stall", {31'd0, pc_hold}, 0);

    // Redirect: flush two cycles, bubble one, RUN -> FLUSH -> RUN
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    #2;
    checkOutput("br flush c0", {31'd0, if_id_flush}, 1);
    checkOutput("br bubble c0", {31'd0, id_ex_bubble}, 1);
    idleCycle();
    #2;
    checkOutput("br flush c1", {31'd0, if_id_flush}, 1);
    checkOutput("br bubble c1", {31'd0, id_ex_bubble}, 0);
    checkOutput("br state c1", {30'd0, state_o}, 2);
    idleCycle();
    #2;
    checkOutput("br flush c2", {31'd0, if_id_flush}, 0);
    checkOutput("br state c2", {30'd0, state_o}, 0);

    // Memory wait with a pending load-use: hold three cycles, then the stall
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0);
      #2;
      checkOutput("busy ex_mem_hold", {31'd0, ex_mem_hold}, 1);
      checkOutput("busy bubble", {31'd0, id_ex_bubble}, 0);
    end
    applyStimulus(0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0);
    #2;
    checkOutput("release stall", {31'd0, id_ex_bubble}, 1);
    checkOutput("release state", {30'd0, state_o}, 1);
    idleCycle();
    #2;
    checkOutput("busy count", {16'd0, stall_count}, 4);

    // Load-use while in FLUSH: the flush wins
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 0);
    #2;
    checkOutput("flush beats lu flush", {31'd0, if_id_flush}, 1);
    checkOutput("flush beats lu hold", {31'd0, pc_hold}, 0);

    // Reset in the middle of FLUSH
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    idleCycle();
    #1;
    checkOutput("pre-rst flush", {31'd0, if_id_flush}, 1);
    #1;
    rst = 1;
    #1;
    checkOutput("rst flush", {31'd0, if_id_flush}, 0);
    checkOutput("rst state", {30'd0, state_o}, 0);
    idleCycle();

    // Clear during a hold cycle
    applyStimulus(0, 0, 0, 1, 5'd4, 5'd0, 0, 5'd4, 1, 0);
    applyStimulus(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
    #2;
    checkOutput("clr pc_hold", {31'd0, pc_hold}, 1);
    idleCycle();
    #2;
    checkOutput("clr count", {16'd0, stall_count}, 0);

    // Long memory wait drives the counter into saturation
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    end
    idleCycle();
    #2;
    checkOutput("sat count", {16'd0, stall_count}, 32'h0000FFFF);
    checkOutput("sat state", {30'd0, state_o}, 1);
    applyStimulus(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    idleCycle();
    #2;
    checkOutput("sat hold", {16'd0, stall_count}, 32'h0000FFFF);
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 1) == 1),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 19) == 0));
    end
    idleCycle();
    @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
